vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the raster timing that the pixel generator consumes: h_cnt, v_cnt, valid, and the hsync/vsync pins driven to the VGA connector.
- Sits between the clock source and the pixel generator and sprite/ROM address logic.
- Also provides frame_start, line_start and frame_cnt, used by game-state logic for per-frame updates such as ball motion and countdowns.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync active level (0 = active-low)
VSYNC_POL, 0, vsync active level (0 = active-low)
PIX_DIV, 1, clk_25MHz cycles per pixel (1..16)

Ports:
clk_25MHz  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  timing advance enable; low = freeze
h_cnt  output  10  current pixel column, 0..H_TOTAL-1
v_cnt  output  10  current line, 0..V_TOTAL-1
valid  output  1  high when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE
hsync  output  1  horizontal sync, polarity per HSYNC_POL
vsync  output  1  vertical sync, polarity per VSYNC_POL
line_start  output  1  one-cycle pulse when h_cnt becomes 0
frame_start  output  1  one-cycle pulse when (h_cnt, v_cnt) becomes (0, 0)
frame_cnt  output  8  frame counter, increments on each frame_start

Behaviour:
- Clock and reset: one clock, clk_25MHz. rst_n is asynchronous and active-low.
- Derived constants:
  - H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP (default 800).
  - V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP (default 525).
- Pixel tick:
  - A divider counter runs 0..PIX_DIV-1 while en = 1. tick = en && (div == PIX_DIV-1).
  - With PIX_DIV = 1, tick = en on every cycle.
  - en = 0 holds the divider value.
- Counters, on tick:
  - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 when h_cnt also wraps.
- Registered outputs:
  - valid, hsync and vsync are computed from the next counter values and registered.
  - All outputs therefore change in the same cycle as h_cnt/v_cnt and correspond exactly to them, with zero skew.
- hsync active when H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751 by default).
- vsync active when V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491 by default). vsync is line-based and independent of h_cnt.
- Pulses:
  - line_start = 1 for exactly one clk cycle, the cycle in which h_cnt holds 0 following a tick.
  - frame_start behaves the same way, additionally requiring v_cnt = 0.
  - Neither pulse re-asserts while en = 0, even though h_cnt stays at 0.
- frame_cnt increments in the same cycle frame_start asserts and wraps 255 -> 0.
- Reset values, applied immediately and asynchronously:
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, divider = 0.
  - valid = 0; hsync = !HSYNC_POL; vsync = !VSYNC_POL.
  - line_start = 0, frame_start = 0, frame_cnt = 0.
- First tick after reset produces h_cnt = 0, v_cnt = 0, valid = 1, line_start = 1, frame_start = 1 and frame_cnt = 1.
- en = 0: all state is held, line_start and frame_start are 0, and sync/valid hold their levels.
- Reset mid-frame returns every output to its reset value within the same cycle, with no partial pulse.
- Width rules:
  - All counter comparisons are unsigned 10-bit.
  - Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024; no further checking is performed.

Test Plan:
- Reset then release with en = 1, PIX_DIV = 1: during reset h_cnt = 799, v_cnt = 524, valid = 0, hsync = vsync = 1. First clock after release gives h = 0, v = 0, valid = 1, line_start = frame_start = 1, frame_cnt = 1.
- Horizontal window on line 0:
  - h = 639 gives valid = 1; h = 640 gives valid = 0.
  - hsync goes low at h = 656 and back high at h = 752, i.e. exactly 96 cycles low.
  - line_start pulses once per 800 cycles.
- Vertical window:
  - vsync is low for v = 490..491 only, which is 1600 cycles.
  - valid = 0 for all h when v >= 480.
- Full frame: 420000 cycles between consecutive frame_start pulses. After 256 frames, frame_cnt wraps from 255 to 0.
- en toggling: drop en at h = 300 for 10 cycles. h_cnt holds at 300, no pulses occur, then counting resumes at 301.
- PIX_DIV = 4:
  - Each h_cnt value lasts 4 cycles and line_start lasts 1 cycle.
  - Asserting rst_n = 0 at v = 200 immediately restores the reset values.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick divider, h/v counters, registered sync/valid
// and per-line/per-frame pulses, all aligned to the counter values.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIX_DIV   = 1
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic       HS_ON  = (HSYNC_POL != 0);
  localparam logic       VS_ON  = (VSYNC_POL != 0);

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] h_nxt, v_nxt;
  logic       valid_q, valid_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic [7:0] fc_q, fc_d;
  logic       tick;

  always_comb begin
    tick  = en && (div_q == DIV_LAST);
    div_d = div_q;
    if (en) div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;

    h_nxt = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_nxt = v_q;
    if (h_q == H_LAST) v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;

    h_d     = h_q;
    v_d     = v_q;
    valid_d = valid_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    fc_d    = fc_q;

    // Decode from the next counter values so registered outputs line up with h/v.
    if (tick) begin
      h_d     = h_nxt;
      v_d     = v_nxt;
      valid_d = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hsync_d = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? HS_ON : ~HS_ON;
      vsync_d = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? VS_ON : ~VS_ON;
      ls_d    = (h_nxt == 10'd0);
      fs_d    = (h_nxt == 10'd0) && (v_nxt == 10'd0);
      fc_d    = fs_d ? fc_q + 8'd1 : fc_q;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= 4'd0;
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      valid_q <= 1'b0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= 8'd0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      valid_q <= valid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign valid       = valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a shrunk raster
// for whole-frame and frame counter wrap behaviour, and a divided pixel clock.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: default timing; b: 16x10 raster; c: 16x10 raster with PIX_DIV = 4
  logic       rst_a = 1'b0, en_a = 1'b1;
  logic       rst_b = 1'b0, en_b = 1'b1;
  logic       rst_c = 1'b0, en_c = 1'b1;
  logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
  logic       val_a, hs_a, vs_a, ls_a, fs_a;
  logic       val_b, hs_b, vs_b, ls_b, fs_b;
  logic       val_c, hs_c, vs_c, ls_c, fs_c;
  logic [7:0] fc_a, fc_b, fc_c;

  vga_timing_gen dut_a (
    .clk_25MHz(clk), .rst_n(rst_a), .en(en_a), .h_cnt(h_a), .v_cnt(v_a),
    .valid(val_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(1)
  ) dut_b (
    .clk_25MHz(clk), .rst_n(rst_b), .en(en_b), .h_cnt(h_b), .v_cnt(v_b),
    .valid(val_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_cnt(fc_b)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(4)
  ) dut_c (
    .clk_25MHz(clk), .rst_n(rst_c), .en(en_c), .h_cnt(h_c), .v_cnt(v_c),
    .valid(val_c), .hsync(hs_c), .vsync(vs_c), .line_start(ls_c),
    .frame_start(fs_c), .frame_cnt(fc_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks; sampling happens 1ns after the active edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n, lsn, hs_lo, vs_lo, vcnt, bad, period;

    // ---------------- default timing ----------------
    cyc(3);
    chk("a_rst_h", 32'(h_a), 799);
    chk("a_rst_v", 32'(v_a), 524);
    chk("a_rst_valid", 32'(val_a), 0);
    chk("a_rst_hsync", 32'(hs_a), 1);
    chk("a_rst_vsync", 32'(vs_a), 1);
    chk("a_rst_pulses", {30'd0, ls_a, fs_a}, 0);
    chk("a_rst_fcnt", 32'(fc_a), 0);

    rst_a = 1'b1;
    cyc(1);
    chk("a_first_h", 32'(h_a), 0);
    chk("a_first_v", 32'(v_a), 0);
    chk("a_first_valid", 32'(val_a), 1);
    chk("a_first_pulses", {30'd0, ls_a, fs_a}, 3);
    chk("a_first_fcnt", 32'(fc_a), 1);

    cyc(639);
    chk("a_h639_valid", 32'(val_a), 1);
    chk("a_h639_ls", 32'(ls_a), 0);
    cyc(1);
    chk("a_h640_h", 32'(h_a), 640);
    chk("a_h640_valid", 32'(val_a), 0);
    cyc(15);
    chk("a_h655_hsync", 32'(hs_a), 1);
    cyc(1);
    chk("a_h656_hsync", 32'(hs_a), 0);
    cyc(95);
    chk("a_h751_hsync", 32'(hs_a), 0);
    cyc(1);
    chk("a_h752_hsync", 32'(hs_a), 1);

    lsn = 0;
    for (int i = 0; i < 800; i++) begin
      cyc(1);
      if (ls_a) lsn++;
    end
    chk("a_ls_per_line", 32'(lsn), 1);
    chk("a_line1_v", 32'(v_a), 1);
    chk("a_line1_h", 32'(h_a), 752);

    cyc(348);
    chk("a_pre_hold_h", 32'(h_a), 300);
    chk("a_pre_hold_v", 32'(v_a), 2);
    en_a = 1'b0;
    lsn = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (ls_a || fs_a) lsn++;
      if (h_a != 10'd300 || val_a != 1'b1 || hs_a != 1'b1) bad++;
    end
    chk("a_hold_pulses", 32'(lsn), 0);
    chk("a_hold_state", 32'(bad), 0);
    en_a = 1'b1;
    cyc(1);
    chk("a_resume_h", 32'(h_a), 301);

    // ---------------- 16x10 raster ----------------
    rst_b = 1'b1;
    cyc(1);
    chk("b_first_fs", 32'(fs_b), 1);
    chk("b_first_fcnt", 32'(fc_b), 1);
    period = 0;
    hs_lo = 0;
    vs_lo = 0;
    vcnt = 0;
    bad = 0;
    for (int i = 1; i <= 160; i++) begin
      cyc(1);
      if (fs_b && period == 0) period = i;
      if (!hs_b) hs_lo++;
      if (!vs_b) vs_lo++;
      if (val_b) vcnt++;
      if (val_b && v_b >= 10'd6) bad++;
      if (!vs_b && !(v_b == 10'd7 || v_b == 10'd8)) bad++;
    end
    chk("b_frame_period", 32'(period), 160);
    chk("b_hsync_low", 32'(hs_lo), 30);
    chk("b_vsync_low", 32'(vs_lo), 32);
    chk("b_valid_cycles", 32'(vcnt), 48);
    chk("b_window_errs", 32'(bad), 0);
    chk("b_frame2_fcnt", 32'(fc_b), 2);

    cyc(253 * 160);
    chk("b_fcnt_255", 32'(fc_b), 255);
    chk("b_fs_255", 32'(fs_b), 1);
    cyc(160);
    chk("b_fcnt_wrap", 32'(fc_b), 0);
    chk("b_fs_wrap", 32'(fs_b), 1);

    // ---------------- divided pixel clock ----------------
    rst_c = 1'b1;
    cyc(3);
    chk("c_pre_tick_h", 32'(h_c), 15);
    cyc(1);
    chk("c_tick_h", 32'(h_c), 0);
    chk("c_tick_ls", 32'(ls_c), 1);
    chk("c_tick_fcnt", 32'(fc_c), 1);
    cyc(1);
    chk("c_ls_one_cycle", 32'(ls_c), 0);
    chk("c_h_hold", 32'(h_c), 0);
    cyc(2);
    chk("c_h_hold4", 32'(h_c), 0);
    cyc(1);
    chk("c_h_next", 32'(h_c), 1);

    n = 0;
    lsn = 0;
    while (v_c != 10'd5 && n < 1000) begin
      cyc(1);
      n++;
      if (ls_c) lsn++;
    end
    chk("c_cycles_to_v5", 32'(n), 316);
    chk("c_ls_cycles", 32'(lsn), 5);

    #2 rst_c = 1'b0;
    #1;
    chk("c_async_h", 32'(h_c), 15);
    chk("c_async_v", 32'(v_c), 9);
    chk("c_async_valid", 32'(val_c), 0);
    chk("c_async_sync", {30'd0, hs_c, vs_c}, 3);
    chk("c_async_pulses", {30'd0, ls_c, fs_c}, 0);
    chk("c_async_fcnt", 32'(fc_c), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
